// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and data access. Data wins ties, except that after MAX_DATA_STREAK
// consecutive data grants with fetch waiting, fetch is served next. One access
// is in flight at a time. The owner gets a one-cycle ack with registered read
// data.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_ack,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mc_req,
  output logic                  mc_we,
  output logic [ADDR_WIDTH-1:0] mc_addr,
  output logic [DATA_WIDTH-1:0] mc_wdata,
  input  logic                  mc_ready,
  input  logic [DATA_WIDTH-1:0] mc_rdata,
  output logic                  busy
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1'b1);
  localparam logic [STREAK_W-1:0] STREAK_ZERO = {STREAK_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  state_t                state_r,    state_s;
  owner_t                owner_r,    owner_s;
  logic [STREAK_W-1:0]   streak_r,   streak_s;
  logic                  mc_req_r,   mc_req_s;
  logic                  mc_we_r,    mc_we_s;
  logic [ADDR_WIDTH-1:0] mc_addr_r,  mc_addr_s;
  logic [DATA_WIDTH-1:0] mc_wdata_r, mc_wdata_s;
  logic                  if_ack_r,   if_ack_s;
  logic                  dm_ack_r,   dm_ack_s;
  logic [DATA_WIDTH-1:0] if_rdata_r, if_rdata_s;
  logic [DATA_WIDTH-1:0] dm_rdata_r, dm_rdata_s;
  logic                  busy_r,     busy_s;
  logic                  streak_full_s;

  assign streak_full_s = (streak_r == STREAK_MAX);

  // Next-state, grant decision and next values of every registered output.
  always_comb begin
    state_s    = state_r;
    owner_s    = owner_r;
    streak_s   = streak_r;
    mc_req_s   = mc_req_r;
    mc_we_s    = mc_we_r;
    mc_addr_s  = mc_addr_r;
    mc_wdata_s = mc_wdata_r;
    if_ack_s   = 1'b0;
    dm_ack_s   = 1'b0;
    if_rdata_s = if_rdata_r;
    dm_rdata_s = dm_rdata_r;
    busy_s     = busy_r;

    case (state_r)
      ST_IDLE: begin
        // Fetch takes a tie only when the data streak has saturated.
        if (dm_req && !(if_req && streak_full_s)) begin
          state_s    = ST_BUSY;
          owner_s    = OWN_DATA;
          mc_req_s   = 1'b1;
          mc_we_s    = dm_we;
          mc_addr_s  = dm_addr;
          mc_wdata_s = dm_wdata;
          busy_s     = 1'b1;
          if (if_req) begin
            if (streak_full_s) begin
              streak_s = streak_r;
            end else begin
              streak_s = streak_r + STREAK_ONE;
            end
          end else begin
            streak_s = STREAK_ZERO;
          end
        end else if (if_req) begin
          state_s    = ST_BUSY;
          owner_s    = OWN_FETCH;
          mc_req_s   = 1'b1;
          mc_we_s    = 1'b0;
          mc_addr_s  = if_addr;
          mc_wdata_s = {DATA_WIDTH{1'b0}};
          busy_s     = 1'b1;
          streak_s   = STREAK_ZERO;
        end else begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end
      end

      ST_BUSY: begin
        // The memory side request stays frozen until the controller completes.
        if (mc_ready) begin
          state_s  = ST_RESP;
          mc_req_s = 1'b0;
          mc_we_s  = 1'b0;
          if (owner_r == OWN_FETCH) begin
            if_ack_s   = 1'b1;
            if_rdata_s = mc_rdata;
          end else begin
            dm_ack_s = 1'b1;
            if (!mc_we_r) begin
              dm_rdata_s = mc_rdata;
            end else begin
              dm_rdata_s = dm_rdata_r;
            end
          end
        end else begin
          state_s = ST_BUSY;
        end
      end

      ST_RESP: begin
        // Ack is visible this cycle only; requests are not looked at here.
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end

      default: begin
        state_s  = ST_IDLE;
        busy_s   = 1'b0;
        mc_req_s = 1'b0;
        mc_we_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset; an in-flight access is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      owner_r    <= OWN_FETCH;
      streak_r   <= STREAK_ZERO;
      mc_req_r   <= 1'b0;
      mc_we_r    <= 1'b0;
      mc_addr_r  <= {ADDR_WIDTH{1'b0}};
      mc_wdata_r <= {DATA_WIDTH{1'b0}};
      if_ack_r   <= 1'b0;
      dm_ack_r   <= 1'b0;
      if_rdata_r <= {DATA_WIDTH{1'b0}};
      dm_rdata_r <= {DATA_WIDTH{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      streak_r   <= streak_s;
      mc_req_r   <= mc_req_s;
      mc_we_r    <= mc_we_s;
      mc_addr_r  <= mc_addr_s;
      mc_wdata_r <= mc_wdata_s;
      if_ack_r   <= if_ack_s;
      dm_ack_r   <= dm_ack_s;
      if_rdata_r <= if_rdata_s;
      dm_rdata_r <= dm_rdata_s;
      busy_r     <= busy_s;
    end
  end

  assign mc_req   = mc_req_r;
  assign mc_we    = mc_we_r;
  assign mc_addr  = mc_addr_r;
  assign mc_wdata = mc_wdata_r;
  assign if_ack   = if_ack_r;
  assign dm_ack   = dm_ack_r;
  assign if_rdata = if_rdata_r;
  assign dm_rdata = dm_rdata_r;
  assign busy     = busy_r;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer sharing one single-port unified memory between the Fetch stage (instruction reads) and the Memory stage (data reads/writes). It accepts requests from both stages, grants one at a time, runs a req/ready handshake toward the memory controller, and returns a one-cycle acknowledge with registered read data to the winner. Data accesses have priority; a streak counter guarantees fetch progress. It sits between the Fetch/Memory stages and the memory controller, in the divided pipeline clock domain.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch waits (≥1)

- clock  in  1  pipeline clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- if_req  in  1  fetch read request; held with if_addr until if_ack
- if_addr  in  ADDR_WIDTH  fetch address
- if_ack  out  1  one-cycle pulse: fetch access complete
- if_rdata  out  DATA_WIDTH  instruction word, valid with if_ack, held until next fetch ack
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_ack
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  write data
- dm_ack  out  1  one-cycle pulse: data access complete
- dm_rdata  out  DATA_WIDTH  read data, updated only on read completion, held otherwise
- mc_req  out  1  memory request, held until mc_ready sampled high
- mc_we  out  1  write strobe to memory
- mc_addr  out  ADDR_WIDTH  memory address
- mc_wdata  out  DATA_WIDTH  memory write data
- mc_ready  in  1  memory completes current access this cycle; ignored when mc_req=0
- mc_rdata  in  DATA_WIDTH  memory read data, valid when mc_ready=1
- busy  out  1  1 whenever state ≠ IDLE

## Operation
- States: IDLE, BUSY, RESP. Registered grant owner `owner` (FETCH/DATA).
- IDLE: sample requests. Neither → stay. Only one → grant it. Both → grant DATA unless streak == MAX_DATA_STREAK, then FETCH. On grant: latch addr/we/wdata into mc_* registers (fetch: mc_we=0, mc_wdata=0), mc_req←1, go BUSY.
- BUSY: hold mc_* stable. On mc_ready=1: mc_req←0, mc_we←0; capture mc_rdata into if_rdata (FETCH) or dm_rdata (DATA read only); assert owner's ack; go RESP.
- RESP: ack high exactly this cycle; requests ignored; next state IDLE. Requester must drop or change req by end of RESP; req still high in IDLE is a new request.
- Streak counter (width ≥ clog2(MAX_DATA_STREAK+1)): on DATA grant with if_req=1 → increment, saturating at MAX_DATA_STREAK; on DATA grant with if_req=0 → clear; on FETCH grant → clear.
- No requests are queued; inputs are only sampled in IDLE.
- Reset (any state, including mid-BUSY): state IDLE, mc_req/mc_we/if_ack/dm_ack/busy=0, mc_addr/mc_wdata/if_rdata/dm_rdata=0, streak=0. An interrupted access is abandoned with no ack.

## Timing
- All outputs registered.
- Request seen in IDLE at cycle 0 → mc_req=1 from cycle 1 → mc_ready high at cycle k (k≥1) → ack and rdata at cycle k+1 → IDLE at k+2.
- Minimum access: 3 cycles (ready in cycle 1, ack cycle 2); back-to-back grant earliest cycle 3.
- mc_ready stalls extend BUSY indefinitely; no timeout.
- Both requests in same IDLE cycle: exactly one granted; the loser waits in IDLE of the following transaction.
- if_ack and dm_ack never high in the same cycle; at most one of them high per transaction.

## Test plan
- Reset: hold reset 2 cycles mid-BUSY (mc_req=1) → next cycle mc_req=0, busy=0, no ack, all data outputs 0.
- Single fetch: if_req, if_addr=0x0000_0040, mc_ready tied 1, mc_rdata=0x2008_0005 → mc_req cycle 1 with mc_addr=0x40, mc_we=0; if_ack cycle 2, if_rdata=0x2008_0005.
- Data write with stall: dm_req, dm_we=1, dm_addr=0x100, dm_wdata=0xDEAD_BEEF, mc_ready low 3 cycles → mc_req/mc_we/mc_wdata stable 4 cycles, dm_ack one cycle later, dm_rdata unchanged.
- Simultaneous: if_req and dm_req (read, addr 0x200) in IDLE, streak 0 → DATA served first, then FETCH; dm_ack precedes if_ack by 3 cycles with ready tied 1.
- Starvation guard: if_req held high, dm_req re-asserted every IDLE, MAX_DATA_STREAK=4 → exactly 4 dm_acks, then 1 if_ack, counter cleared, pattern repeats.
- Re-request: requester keeps req high through RESP → second, distinct access with second ack; no duplicate ack within one transaction.
